// File: rtl/pooling_stream_scheduler.sv
// pooling_stream_scheduler: sequential nxn average pooling over a raster-order pixel stream.
// Define AVG_POOL_ROUND_EN for round-half-up (saturating) averages; default is truncating.
module pooling_stream_scheduler #(
   parameter int resolution                = 8,
   parameter int n                         = 2,
   parameter int input_matrix_side_length  = 28,
   parameter int output_matrix_side_length = input_matrix_side_length >> $clog2(n)
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic                                             start,
   output logic                                             busy,
   output logic                                             done,
   input  logic                                             in_valid,
   output logic                                             in_ready,
   input  logic [resolution-1:0]                            in_pixel,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [resolution-1:0]                            out_pixel,
   output logic [$clog2(output_matrix_side_length**2)-1:0]  out_index
);
   localparam int LOGN  = $clog2(n);
   localparam int SH    = 2 * LOGN;
   localparam int ACC_W = resolution + SH;
   localparam int CW    = $clog2(input_matrix_side_length);
   localparam int PW    = (output_matrix_side_length > 1) ? $clog2(output_matrix_side_length) : 1;
   localparam int IW    = $clog2(output_matrix_side_length**2);
   localparam logic [CW-1:0] LAST = CW'(input_matrix_side_length - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         row_q, row_d, col_q, col_d;
   logic [ACC_W-1:0]      acc_q [output_matrix_side_length];
   logic [ACC_W-1:0]      acc_d;
   logic                  out_valid_q, out_valid_d;
   logic [resolution-1:0] out_pixel_q, out_pixel_d;
   logic [IW-1:0]         out_index_q, out_index_d;

   logic                  in_fire, out_fire, first_px, pool_done, last_beat;
   logic [PW-1:0]         pool;
   logic [ACC_W-1:0]      sum;
   logic [resolution-1:0] avg;

   assign pool      = PW'(col_q >> LOGN);
   assign first_px  = (row_q[LOGN-1:0] == '0) & (col_q[LOGN-1:0] == '0);
   assign pool_done = (&row_q[LOGN-1:0]) & (&col_q[LOGN-1:0]);
   assign last_beat = (row_q == LAST) & (col_q == LAST);
   assign sum       = acc_q[pool] + ACC_W'(in_pixel);
   assign acc_d     = first_px ? ACC_W'(in_pixel) : sum;

`ifdef AVG_POOL_ROUND_EN
   localparam logic [ACC_W:0] BIAS = (ACC_W + 1)'(2 ** (SH - 1));
   logic [ACC_W:0]        rsum;
   logic [resolution:0]   rq;
   assign rsum = {1'b0, sum} + BIAS;
   assign rq   = rsum[ACC_W:SH];
   assign avg  = rq[resolution] ? '1 : rq[resolution-1:0];
`else
   assign avg  = sum[ACC_W-1:SH];
`endif

   assign in_ready  = (state_q == S_RUN) & (!out_valid_q | out_ready);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid_q & out_ready;
   assign busy      = (state_q == S_RUN) | (state_q == S_FLUSH);
   assign done      = (state_q == S_DONE);
   assign out_valid = out_valid_q;
   assign out_pixel = out_pixel_q;
   assign out_index = out_index_q;

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      out_valid_d = out_valid_q;
      out_pixel_d = out_pixel_q;
      out_index_d = out_index_q;

      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (in_fire && last_beat) state_d = S_FLUSH;
         S_FLUSH: if (out_fire) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (in_fire) begin
         if (col_q == LAST) begin
            col_d = '0;
            row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      // A completing beat may be accepted in the same cycle the previous result drains.
      if (out_fire) out_valid_d = 1'b0;
      if (in_fire && pool_done) begin
         out_valid_d = 1'b1;
         out_pixel_d = avg;
         out_index_d = IW'(row_q >> LOGN) * IW'(output_matrix_side_length) + IW'(pool);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         acc_q       <= '{default: '0};
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         out_index_q <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         out_valid_q <= out_valid_d;
         out_pixel_q <= out_pixel_d;
         out_index_q <= out_index_d;
         if (in_fire) acc_q[pool] <= acc_d;
      end
   end

endmodule

// File: tb/tb_pooling_stream_scheduler.sv
// Scoreboard bench for pooling_stream_scheduler: a 4x4 instance and a 28x28 instance share stimulus.
module tb_pooling_stream_scheduler;
   logic clk = 1'b0;
   logic rst_n;
   logic sel, start, in_valid, out_ready;
   logic [7:0] in_pixel;

   logic       a_busy, a_done, a_in_ready, a_out_valid;
   logic [7:0] a_out_pixel;
   logic [1:0] a_out_index;
   logic       b_busy, b_done, b_in_ready, b_out_valid;
   logic [7:0] b_out_pixel;
   logic [7:0] b_out_index;
   logic       start_a, start_b;

   logic       busy, done, in_ready, out_valid;
   logic [7:0] out_pixel, out_index;

   int checks = 0;
   int failures = 0;
   int exp_px_q[$];
   int exp_idx_q[$];
   int log_px[$];

   assign start_a   = start & !sel;
   assign start_b   = start & sel;
   assign busy      = sel ? b_busy      : a_busy;
   assign done      = sel ? b_done      : a_done;
   assign in_ready  = sel ? b_in_ready  : a_in_ready;
   assign out_valid = sel ? b_out_valid : a_out_valid;
   assign out_pixel = sel ? b_out_pixel : a_out_pixel;
   assign out_index = sel ? b_out_index : {6'b0, a_out_index};

   pooling_stream_scheduler #(
      .resolution(8), .n(2), .input_matrix_side_length(4)
   ) u_a (
      .clk(clk), .reset(rst_n), .start(start_a), .busy(a_busy), .done(a_done),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_pixel(in_pixel),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_pixel(a_out_pixel),
      .out_index(a_out_index)
   );

   pooling_stream_scheduler #(
      .resolution(8), .n(2), .input_matrix_side_length(28)
   ) u_b (
      .clk(clk), .reset(rst_n), .start(start_b), .busy(b_busy), .done(b_done),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_pixel(in_pixel),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_pixel(b_out_pixel),
      .out_index(b_out_index)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pix_for(input int mode, input int beat);
      if (mode == 0) return beat[7:0];
      if (mode == 1) return 8'd255;
      return 8'($urandom_range(255));
   endfunction

   function automatic int avg_of(input int s);
      int e;
`ifdef AVG_POOL_ROUND_EN
      e = (s + 2) / 4;
      if (e > 255) e = 255;
`else
      e = s / 4;
`endif
      return e;
   endfunction

   // Drives one frame and checks every output against the scoreboard; abort_beat>=0 stops early.
   task automatic run_frame(input int side, input int mode, input int vprob, input int rprob,
                            input int stall_len, input int abort_beat);
      int macc[14];
      int beats, outs, cyc, post, dones, stall_left, r, c, p, e, ei, os;
      bit seen_first, seen_done;
      logic [7:0] px, hold_px, hold_idx;
      beats = 0; outs = 0; cyc = 0; post = 0; dones = 0; stall_left = 0;
      seen_first = 0; seen_done = 0; os = side / 2;
      hold_px = '0; hold_idx = '0;
      foreach (macc[k]) macc[k] = 0;
      px = pix_for(mode, 0);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL busy_after_start: got %b want 1", busy);
      end
      while (post < 3 && cyc < 20000) begin
         if (out_valid === 1'b1 && !seen_first) begin
            seen_first = 1; stall_left = stall_len; hold_px = out_pixel; hold_idx = out_index;
         end
         in_valid  = (beats < side * side) && (int'($urandom_range(99)) < vprob);
         in_pixel  = px;
         out_ready = (stall_left > 0) ? 1'b0 : (int'($urandom_range(99)) < rprob);
         #1;
         if (stall_left > 0) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pixel !== hold_px || out_index !== hold_idx) begin
               failures++;
               $display("FAIL stall_hold: got rdy=%b v=%b px=%0d idx=%0d want rdy=0 v=1 px=%0d idx=%0d",
                        in_ready, out_valid, out_pixel, out_index, hold_px, hold_idx);
            end
            stall_left--;
         end
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (exp_px_q.size() == 0) begin
               failures++; $display("FAIL unexpected_output: got px=%0d idx=%0d want none", out_pixel, out_index);
            end else begin
               e = exp_px_q.pop_front(); ei = exp_idx_q.pop_front();
               if (out_pixel !== e[7:0] || out_index !== ei[7:0]) begin
                  failures++;
                  $display("FAIL out_pixel: got px=%0d idx=%0d want px=%0d idx=%0d", out_pixel, out_index, e, ei);
               end
            end
            log_px.push_back(int'(out_pixel));
            outs++;
         end
         if (in_valid && in_ready === 1'b1) begin
            r = beats / side; c = beats % side; p = c / 2;
            if (r % 2 == 0 && c % 2 == 0) macc[p] = int'(px);
            else macc[p] += int'(px);
            if (r % 2 == 1 && c % 2 == 1) begin
               exp_px_q.push_back(avg_of(macc[p]));
               exp_idx_q.push_back((r / 2) * os + p);
            end
            beats++;
            px = pix_for(mode, beats);
         end
         if (done === 1'b1) dones++;
         if (seen_done) post++;
         else if (done === 1'b1) seen_done = 1;
         if (abort_beat >= 0 && beats == abort_beat) return;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (cyc >= 20000) begin
         failures++; $display("FAIL frame_timeout: got %0d cycles want <20000", cyc);
      end
      checks++;
      if (outs != os * os || beats != side * side) begin
         failures++; $display("FAIL frame_counts: got outs=%0d beats=%0d want outs=%0d beats=%0d",
                              outs, beats, os * os, side * side);
      end
      checks++;
      if (dones != 1) begin
         failures++; $display("FAIL done_once: got %0d pulses want 1", dones);
      end
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || exp_px_q.size() != 0) begin
         failures++; $display("FAIL idle_after_done: got busy=%b rdy=%b pending=%0d want 0 0 0",
                              busy, in_ready, exp_px_q.size());
      end
   endtask

   task automatic test_reset();
      sel = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
      rst_n = 1'b0;
      #3;
      checks++;
      if ({a_busy, a_done, a_in_ready, a_out_valid, a_out_pixel, a_out_index} !== '0) begin
         failures++; $display("FAIL reset_a: got %b want all zero",
                              {a_busy, a_done, a_in_ready, a_out_valid, a_out_pixel, a_out_index});
      end
      checks++;
      if ({b_busy, b_done, b_in_ready, b_out_valid, b_out_pixel, b_out_index} !== '0) begin
         failures++; $display("FAIL reset_b: got %b want all zero",
                              {b_busy, b_done, b_in_ready, b_out_valid, b_out_pixel, b_out_index});
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_ramp();
      int want[4];
`ifdef AVG_POOL_ROUND_EN
      want = '{3, 5, 11, 13};
`else
      want = '{2, 4, 10, 12};
`endif
      sel = 1'b0; log_px.delete();
      run_frame(4, 0, 100, 100, 0, -1);
      checks++;
      if (log_px.size() != 4 || log_px[0] != want[0] || log_px[1] != want[1] ||
          log_px[2] != want[2] || log_px[3] != want[3]) begin
         failures++; $display("FAIL ramp_values: got %p want %p", log_px, want);
      end
   endtask

   task automatic test_saturate();
      sel = 1'b0; log_px.delete();
      run_frame(4, 1, 100, 100, 0, -1);
      checks++;
      if (log_px.size() != 4 || log_px[0] != 255 || log_px[1] != 255 ||
          log_px[2] != 255 || log_px[3] != 255) begin
         failures++; $display("FAIL all_255: got %p want four 255", log_px);
      end
   endtask

   task automatic test_backpressure();
      sel = 1'b0; log_px.delete();
      run_frame(4, 0, 100, 100, 10, -1);
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      run_frame(4, 2, 60, 50, 0, -1);
      run_frame(4, 2, 60, 50, 0, -1);
   endtask

   task automatic test_random_28();
      sel = 1'b1;
      run_frame(28, 2, 70, 70, 0, -1);
      sel = 1'b0;
   endtask

   task automatic test_reset_midframe();
      sel = 1'b0;
      run_frame(4, 0, 100, 100, 0, 7);
      in_valid = 1'b0; out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({a_busy, a_done, a_in_ready, a_out_valid, a_out_pixel, a_out_index} !== '0) begin
         failures++; $display("FAIL midframe_reset: got %b want all zero",
                              {a_busy, a_done, a_in_ready, a_out_valid, a_out_pixel, a_out_index});
      end
      #2 rst_n = 1'b1;
      exp_px_q.delete(); exp_idx_q.delete();
      test_ramp();
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_saturate();
      test_backpressure();
      test_back_to_back();
      test_random_28();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
